ram2_port_arbiter: RTL and testbench
====================================

Name: ram2_port_arbiter

Overview:
- Shares one RAM2 instance (32 entries x 32 bits: one write port, read port 0) between NUM_REQ HLS-generated requesters.
- Each requester gets a valid/ready request channel and a fixed-latency read-response channel.
- Reads and writes are arbitrated independently with round-robin. In one cycle a read from one client and a write from another can both issue.
- Sits between the generated kernels and RAM2. Read port 1 and the debug ports are not touched.

Parameters:
- NUM_REQ, 2, number of requesters (2..8)
- ADDR_W, 5, RAM2 address width
- DATA_W, 32, RAM2 data width
- RD_LAT, 1, cycles from raddr0 presented to rdata0 valid (1..4)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- req_valid  in  NUM_REQ  per-client request valid
- req_we  in  NUM_REQ  per-client: 1 = write, 0 = read
- req_addr  in  NUM_REQ*ADDR_W  packed; client i at [i*ADDR_W +: ADDR_W]
- req_wdata  in  NUM_REQ*DATA_W  packed write data
- req_ready  out  NUM_REQ  per-client accept
- resp_valid  out  NUM_REQ  per-client read data valid (1-cycle pulse)
- resp_data  out  DATA_W  read data, shared by all clients, qualified by resp_valid
- raddr0  out  ADDR_W  to RAM2 read port 0
- rdata0  in  DATA_W  from RAM2 read port 0
- waddr  out  ADDR_W  to RAM2 write port
- wdata  out  DATA_W  to RAM2 write port
- wen  out  1  to RAM2 write enable

Behaviour:
- Reset (async, rst=1):
  - req_ready=0, resp_valid=0, resp_data=0, wen=0, raddr0=0, waddr=0, wdata=0.
  - Both round-robin pointers=0.
  - Response pipeline cleared; in-flight reads are dropped and never produce resp_valid.
  - No requests are accepted while rst=1.
- Read arbitration (combinational, same cycle):
  - Candidates: req_valid[i] & ~req_we[i].
  - Grant goes to the first candidate at or after rd_ptr, wrapping modulo NUM_REQ.
  - req_ready[g]=1 and raddr0=req_addr[g].
  - If there is no candidate, raddr0 holds its last value.
- Write arbitration (combinational, same cycle):
  - Candidates: req_valid[i] & req_we[i].
  - Grant goes to the first candidate at or after wr_ptr, wrapping.
  - wen=1, waddr and wdata taken from the granted client, req_ready[g]=1.
  - If there is no write grant, wen=0.
- Handshake:
  - A transfer occurs when req_valid & req_ready are both high in the same cycle.
  - Ungranted clients see req_ready=0 and must hold valid, we, addr and wdata stable until accepted.
  - req_ready never rises without req_valid.
- Pointer update (clk edge):
  - After a read grant to g, rd_ptr = (g+1) mod NUM_REQ; likewise wr_ptr after a write grant.
  - A pointer is unchanged when its port has no grant.
- Response path:
  - The read grant ID goes into an RD_LAT-deep shift register of {valid, id}.
  - At the output stage, resp_valid[id]=1 and resp_data=rdata0, both registered.
  - The response appears RD_LAT+1 cycles after acceptance.
  - Back-to-back reads give back-to-back responses in issue order, one per cycle.
- Same-address read and write in the same cycle: the read returns the pre-write value (RAM2 commits the write at the edge). A write followed one cycle later by a read of that address returns the new value.
- One client cannot get a read and a write in the same cycle, since it has one request channel.
- NUM_REQ=1: the pointers stay 0 and the client is always granted.

Decomposition:
- Package ram2_arb_pkg: ADDR_W and DATA_W defaults, RD_LAT default, and the client-ID width constant ID_W = clog2(NUM_REQ), minimum 1.
- One sub-module, rr_arbiter (NUM_REQ request vector, pointer register, one-hot grant out, grant-valid). It is instantiated twice, once for reads and once for writes.
- Request muxing and the response shift register live in the top level.

Test Plan:
- Reset mid-read:
  - Stimulus: client 0 reads addr 3 and is accepted; rst pulses 1 before the response emerges.
  - Required: resp_valid stays 0 after reset; req_ready=0 and wen=0 throughout reset.
- Single write then read:
  - Stimulus: client 1 writes 34 to addr 2; next cycle client 0 reads addr 2.
  - Required: wen=1, waddr=2, wdata=34 for one cycle; resp_valid[0]=1 with resp_data=34, RD_LAT+1 cycles after the read acceptance.
- Round-robin reads:
  - Stimulus: clients 0 and 1 hold continuous reads (addrs 4 and 5) for 6 cycles.
  - Required: grants alternate 0,1,0,1,0,1; raddr0 sequence 4,5,4,5,...; responses return to matching IDs in order.
- Concurrent ports:
  - Stimulus: client 0 reads addr 7 while client 1 writes 99 to addr 7 in the same cycle.
  - Required: both req_ready=1; the response carries the old value; a re-read next cycle returns 99.
- Write fairness:
  - Stimulus: both clients request writes (addr 1 = 10, addr 1 = 20) continuously.
  - Required: wen stays high; grant alternates; the final addr 1 value matches the last granted client.
- Hold-stable:
  - Stimulus: client 1 is blocked for 1 cycle by client 0's grant.
  - Required: client 1 is accepted next cycle with unchanged addr and data; no duplicate or lost transfer.

Source files
------------

// File: rtl/ram2_port_arbiter_pkg.sv
// ram2_arb_pkg: shared defaults and client-ID width helper for the RAM2 port arbiter.
package ram2_arb_pkg;
   localparam int ADDR_W_DEF = 5;
   localparam int DATA_W_DEF = 32;
   localparam int RD_LAT_DEF = 1;
   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/ram2_port_arbiter_rr_arbiter.sv
// rr_arbiter: round-robin arbiter, first request at or after the pointer wins, pointer moves past the winner.
module rr_arbiter
   import ram2_arb_pkg::*;
#(
   parameter int N = 2,
   localparam int ID_W = id_width(N)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N-1:0]    req,
   output logic [N-1:0]    gnt,
   output logic [ID_W-1:0] gid,
   output logic            gv
);
   logic [ID_W-1:0] ptr;
   always_comb begin
      gnt = '0;
      gid = '0;
      gv  = 1'b0;
      for (int k = 0; k < N; k++) begin
         if (!gv && req[(int'(ptr) + k) % N]) begin
            gv = 1'b1;
            gnt[(int'(ptr) + k) % N] = 1'b1;
            gid = ID_W'((int'(ptr) + k) % N);
         end
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) ptr <= '0;
      else if (gv) ptr <= (gid == ID_W'(N - 1)) ? '0 : gid + 1'b1;
   end
endmodule

// File: rtl/ram2_port_arbiter.sv
// ram2_port_arbiter: shares RAM2 write port and read port 0 among NUM_REQ clients,
// independent round-robin for reads and writes, fixed-latency registered read responses.
module ram2_port_arbiter
   import ram2_arb_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int DATA_W  = DATA_W_DEF,
   parameter int RD_LAT  = RD_LAT_DEF
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [NUM_REQ-1:0]         req_we,
   input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
   input  logic [NUM_REQ*DATA_W-1:0]  req_wdata,
   output logic [NUM_REQ-1:0]         req_ready,
   output logic [NUM_REQ-1:0]         resp_valid,
   output logic [DATA_W-1:0]          resp_data,
   output logic [ADDR_W-1:0]          raddr0,
   input  logic [DATA_W-1:0]          rdata0,
   output logic [ADDR_W-1:0]          waddr,
   output logic [DATA_W-1:0]          wdata,
   output logic                       wen
);
   localparam int ID_W = id_width(NUM_REQ);
   logic [NUM_REQ-1:0] rd_req, wr_req, rd_gnt, wr_gnt;
   logic [ID_W-1:0]    rd_id, wr_id;
   logic               rd_gv, wr_gv;
   logic [ADDR_W-1:0]  raddr_q;
   logic [RD_LAT-1:0]  pv;
   logic [ID_W-1:0]    pid [RD_LAT];
   // Masking by rst keeps ready/wen low for the whole reset, not just after it.
   assign rd_req = rst ? '0 : req_valid & ~req_we;
   assign wr_req = rst ? '0 : req_valid & req_we;
   rr_arbiter #(.N(NUM_REQ)) u_rd_arb (
      .clk(clk), .rst(rst), .req(rd_req), .gnt(rd_gnt), .gid(rd_id), .gv(rd_gv)
   );
   rr_arbiter #(.N(NUM_REQ)) u_wr_arb (
      .clk(clk), .rst(rst), .req(wr_req), .gnt(wr_gnt), .gid(wr_id), .gv(wr_gv)
   );
   assign req_ready = rd_gnt | wr_gnt;
   assign raddr0    = rd_gv ? req_addr[int'(rd_id) * ADDR_W +: ADDR_W] : raddr_q;
   assign wen       = wr_gv;
   assign waddr     = wr_gv ? req_addr[int'(wr_id) * ADDR_W +: ADDR_W] : '0;
   assign wdata     = wr_gv ? req_wdata[int'(wr_id) * DATA_W +: DATA_W] : '0;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         raddr_q    <= '0;
         pv         <= '0;
         resp_valid <= '0;
         resp_data  <= '0;
         for (int k = 0; k < RD_LAT; k++) pid[k] <= '0;
      end else begin
         if (rd_gv) raddr_q <= raddr0;
         pv[0]  <= rd_gv;
         pid[0] <= rd_id;
         for (int k = 1; k < RD_LAT; k++) begin
            pv[k]  <= pv[k-1];
            pid[k] <= pid[k-1];
         end
         resp_valid <= pv[RD_LAT-1] ? NUM_REQ'(1) << pid[RD_LAT-1] : '0;
         if (pv[RD_LAT-1]) resp_data <= rdata0;
      end
   end
endmodule

// File: tb/tb_ram2_port_arbiter.sv
// tb_ram2_port_arbiter: directed and randomized checks of ram2_port_arbiter against a transaction-level model.
module tb_ram2_port_arbiter;
   localparam int N = 3, AW = 5, DW = 32, RL = 2;
   logic clk = 0, rst = 1, init_mem = 0;
   logic [N-1:0] req_valid = '0, req_we = '0, req_ready, resp_valid;
   logic [N*AW-1:0] req_addr = '0;
   logic [N*DW-1:0] req_wdata = '0;
   logic [DW-1:0] resp_data, rdata0, wdata;
   logic [AW-1:0] raddr0, waddr;
   logic wen;
   always #5 clk = ~clk;

   ram2_port_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(RL)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_ready(req_ready), .resp_valid(resp_valid), .resp_data(resp_data),
      .raddr0(raddr0), .rdata0(rdata0), .waddr(waddr), .wdata(wdata), .wen(wen)
   );

   function automatic logic [DW-1:0] seed(int i);
      return 32'hA500_0000 + 32'(i * 17);
   endfunction

   // RAM2 stand-in: write commits at the edge, read port pipelined RL deep
   logic [DW-1:0] mem [32];
   logic [DW-1:0] rpipe [RL];
   always @(posedge clk) begin
      if (init_mem) for (int i = 0; i < 32; i++) mem[i] <= seed(i);
      else if (wen) mem[waddr] <= wdata;
      rpipe[0] <= mem[raddr0];
      for (int k = 1; k < RL; k++) rpipe[k] <= rpipe[k-1];
   end
   assign rdata0 = rpipe[RL-1];

   typedef struct packed {
      logic [N-1:0]  ready;
      logic          wen;
      logic [AW-1:0] waddr;
      logic [DW-1:0] wdata;
      logic [AW-1:0] raddr;
      logic [N-1:0]  rv;
      logic [DW-1:0] rd;
   } obs_t;
   typedef struct { int due; int id; logic [DW-1:0] data; } rsp_t;

   rsp_t rq[$];
   logic [DW-1:0] ref_mem [32];
   logic [AW-1:0] last_ra = '0;
   int rp = 0, wp = 0, cyc = 0, n_cmp = 0, n_err = 0;

   function automatic logic [AW-1:0] addr_of(int i);
      return req_addr[i*AW +: AW];
   endfunction
   function automatic logic [DW-1:0] data_of(int i);
      return req_wdata[i*DW +: DW];
   endfunction

   task automatic set_req(int i, logic v, logic we, logic [AW-1:0] a, logic [DW-1:0] d);
      req_valid[i] = v;
      req_we[i] = we;
      req_addr[i*AW +: AW] = a;
      req_wdata[i*DW +: DW] = d;
   endtask

   // One clock of the model: predicts grants, ports and responses, samples the DUT at negedge
   task automatic step(output obs_t a, output obs_t e, output int rg, output int wg);
      int j;
      @(negedge clk);
      rg = -1;
      wg = -1;
      for (int k = 0; k < N; k++) begin
         j = (rp + k) % N;
         if (rg < 0 && req_valid[j] && !req_we[j]) rg = j;
         j = (wp + k) % N;
         if (wg < 0 && req_valid[j] && req_we[j]) wg = j;
      end
      e = '0;
      if (rg >= 0) e.ready[rg] = 1'b1;
      if (wg >= 0) begin
         e.ready[wg] = 1'b1;
         e.wen = 1'b1;
         e.waddr = addr_of(wg);
         e.wdata = data_of(wg);
      end
      e.raddr = (rg >= 0) ? addr_of(rg) : last_ra;
      if (rq.size() > 0 && rq[0].due == cyc) begin
         e.rv[rq[0].id] = 1'b1;
         e.rd = rq[0].data;
         void'(rq.pop_front());
      end
      a.ready = req_ready;
      a.wen = wen;
      a.waddr = wen ? waddr : '0;
      a.wdata = wen ? wdata : '0;
      a.raddr = raddr0;
      a.rv = resp_valid;
      a.rd = (|resp_valid) ? resp_data : '0;
      if (rg >= 0) begin
         rq.push_back('{due: cyc + RL + 1, id: rg, data: ref_mem[addr_of(rg)]});
         last_ra = addr_of(rg);
         rp = (rg + 1) % N;
      end
      if (wg >= 0) begin
         ref_mem[addr_of(wg)] = data_of(wg);
         wp = (wg + 1) % N;
      end
      cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      set_req(0, 1, 0, 3, 0);
      set_req(1, 1, 1, 6, 55);
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         n_cmp++;
         if ({req_ready, wen, resp_valid, raddr0, waddr, wdata, resp_data} !== '0) begin
            n_err++;
            $display("FAIL reset_state: ready=%b wen=%b rv=%b raddr0=%h waddr=%h wdata=%h rdata=%h, want all 0",
                     req_ready, wen, resp_valid, raddr0, waddr, wdata, resp_data);
         end
      end
      req_valid = '0;
      @(posedge clk);
      #1;
      rst = 0;
   endtask

   task automatic test_reset_mid_read();
      obs_t a, e;
      int rg, wg;
      set_req(0, 1, 0, 3, 0);
      step(a, e, rg, wg);
      n_cmp++;
      if (a !== e) begin n_err++; $display("FAIL mid_read_accept: got %h want %h", a, e); end
      req_valid = '0;
      step(a, e, rg, wg);
      n_cmp++;
      if (a !== e) begin n_err++; $display("FAIL mid_read_wait: got %h want %h", a, e); end
      rst = 1;
      set_req(0, 1, 0, 3, 0);
      set_req(1, 1, 1, 4, 77);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         n_cmp++;
         if ({req_ready, wen, resp_valid} !== '0) begin
            n_err++;
            $display("FAIL in_reset: ready=%b wen=%b rv=%b want 0", req_ready, wen, resp_valid);
         end
         @(posedge clk);
         #1;
      end
      req_valid = '0;
      rst = 0;
      rq.delete();
      rp = 0;
      wp = 0;
      last_ra = '0;
      for (int k = 0; k < RL + 2; k++) begin
         step(a, e, rg, wg);
         n_cmp++;
         if (a !== e || a.rv !== '0) begin n_err++; $display("FAIL after_reset: got %h want %h", a, e); end
      end
   endtask

   task automatic test_write_then_read();
      obs_t a, e;
      int rg, wg;
      set_req(1, 1, 1, 2, 34);
      step(a, e, rg, wg);
      n_cmp++;
      if (a !== e || a.wen !== 1'b1 || a.waddr !== 5'd2 || a.wdata !== 32'd34) begin
         n_err++;
         $display("FAIL single_write: got %h want %h", a, e);
      end
      req_valid = '0;
      set_req(0, 1, 0, 2, 0);
      step(a, e, rg, wg);
      n_cmp++;
      if (a !== e || a.wen !== 1'b0) begin n_err++; $display("FAIL read_after_write: got %h want %h", a, e); end
      req_valid = '0;
      for (int k = 1; k <= RL + 2; k++) begin
         step(a, e, rg, wg);
         n_cmp++;
         if (a !== e) begin n_err++; $display("FAIL war_drain: got %h want %h", a, e); end
         n_cmp++;
         if (k == RL + 1 ? (a.rv !== 3'b001 || a.rd !== 32'd34) : (a.rv !== 3'b000)) begin
            n_err++;
            $display("FAIL war_latency k=%0d: rv=%b rd=%0d want rv=%b rd=34", k, a.rv, a.rd,
                     (k == RL + 1) ? 3'b001 : 3'b000);
         end
      end
   endtask

   task automatic test_rr_reads();
      obs_t a, e;
      int rg, wg;
      logic [AW-1:0] prev;
      set_req(0, 1, 0, 4, 0);
      set_req(1, 1, 0, 5, 0);
      for (int k = 0; k < 6; k++) begin
         step(a, e, rg, wg);
         n_cmp++;
         if (a !== e || (k > 0 && a.raddr === prev)) begin
            n_err++;
            $display("FAIL rr_reads k=%0d: got %h want %h", k, a, e);
         end
         prev = a.raddr;
      end
      req_valid = '0;
      for (int k = 0; k < RL + 2; k++) begin
         step(a, e, rg, wg);
         n_cmp++;
         if (a !== e) begin n_err++; $display("FAIL rr_drain: got %h want %h", a, e); end
      end
   endtask

   task automatic test_concurrent();
      obs_t a, e;
      int rg, wg, seen;
      seen = 0;
      set_req(0, 1, 0, 7, 0);
      set_req(1, 1, 1, 7, 99);
      step(a, e, rg, wg);
      n_cmp++;
      if (a !== e || a.ready[1:0] !== 2'b11) begin n_err++; $display("FAIL concurrent: got %h want %h", a, e); end
      req_valid[1] = 1'b0;
      step(a, e, rg, wg);
      n_cmp++;
      if (a !== e) begin n_err++; $display("FAIL reread: got %h want %h", a, e); end
      req_valid = '0;
      for (int k = 0; k < RL + 2; k++) begin
         step(a, e, rg, wg);
         n_cmp++;
         if (a !== e) begin n_err++; $display("FAIL conc_drain: got %h want %h", a, e); end
         if (a.rv[0]) begin
            seen++;
            n_cmp++;
            if (seen == 2 && a.rd !== 32'd99) begin n_err++; $display("FAIL reread_data: got %0d want 99", a.rd); end
         end
      end
      n_cmp++;
      if (seen !== 2) begin n_err++; $display("FAIL conc_count: got %0d responses want 2", seen); end
   endtask

   task automatic test_write_fair();
      obs_t a, e;
      int rg, wg;
      set_req(0, 1, 1, 1, 10);
      set_req(1, 1, 1, 1, 20);
      for (int k = 0; k < 6; k++) begin
         step(a, e, rg, wg);
         n_cmp++;
         if (a !== e || a.wen !== 1'b1) begin n_err++; $display("FAIL write_fair k=%0d: got %h want %h", k, a, e); end
      end
      req_valid = '0;
      set_req(2, 1, 0, 1, 0);
      step(a, e, rg, wg);
      req_valid = '0;
      for (int k = 0; k < RL + 2; k++) begin
         step(a, e, rg, wg);
         n_cmp++;
         if (a !== e) begin n_err++; $display("FAIL fair_drain: got %h want %h", a, e); end
      end
   endtask

   task automatic test_hold();
      obs_t a, e;
      int rg, wg, first;
      set_req(0, 1, 0, 9, 0);
      set_req(1, 1, 0, 10, 0);
      step(a, e, rg, wg);
      first = rg;
      n_cmp++;
      if (a !== e) begin n_err++; $display("FAIL hold_first: got %h want %h", a, e); end
      req_valid[first] = 1'b0;
      step(a, e, rg, wg);
      n_cmp++;
      if (a !== e || a.raddr !== (first == 0 ? 5'd10 : 5'd9) || a.ready !== (first == 0 ? 3'b010 : 3'b001)) begin
         n_err++;
         $display("FAIL hold_second: got %h want %h", a, e);
      end
      req_valid = '0;
      for (int k = 0; k < RL + 2; k++) begin
         step(a, e, rg, wg);
         n_cmp++;
         if (a !== e) begin n_err++; $display("FAIL hold_drain: got %h want %h", a, e); end
      end
      n_cmp++;
      if (rq.size() !== 0) begin n_err++; $display("FAIL hold_lost: %0d responses outstanding want 0", rq.size()); end
   endtask

   task automatic test_random();
      obs_t a, e;
      int rg, wg;
      logic [N-1:0] pend;
      pend = '0;
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!pend[i]) begin
               if ($urandom_range(0, 9) < 6) begin
                  set_req(i, 1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), $urandom);
                  pend[i] = 1'b1;
               end else req_valid[i] = 1'b0;
            end
         end
         step(a, e, rg, wg);
         n_cmp++;
         if (a !== e) begin n_err++; $display("FAIL random c=%0d: got %h want %h", c, a, e); end
         if (rg >= 0) pend[rg] = 1'b0;
         if (wg >= 0) pend[wg] = 1'b0;
      end
      req_valid = '0;
      for (int k = 0; k < RL + 2; k++) begin
         step(a, e, rg, wg);
         n_cmp++;
         if (a !== e) begin n_err++; $display("FAIL random_drain: got %h want %h", a, e); end
      end
   endtask

   initial begin
      for (int i = 0; i < 32; i++) ref_mem[i] = seed(i);
      init_mem = 1;
      repeat (2) @(posedge clk);
      #1;
      init_mem = 0;
      test_reset();
      test_reset_mid_read();
      test_write_then_read();
      test_rr_reads();
      test_concurrent();
      test_write_fair();
      test_hold();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish within 200000 time units");
      $fatal(1);
   end
endmodule
